// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//    Sequences the select (A, B, C) and enable (en) lines of a 3-to-8
//    decoder. Scans the outputs whose mask bit is set in ascending index
//    order. Each slot holds en high for max(dwell, 1) cycles, then holds
//    en low for BLANK_CYC cycles with the select lines unchanged. Runs one
//    pass or wraps continuously (mode_cont).
//
// Ports
//    clk        clock, all logic on posedge
//    rst        synchronous active-high reset
//    start      begin a scan (sampled only while idle)
//    stop       end the scan after the current slot (sampled while busy)
//    mode_cont  1 = wrap to the lowest enabled index, 0 = single pass
//    mask       per-output enable, sampled at each selection point
//    dwell      en-high cycles per slot, 0 behaves as 1
//    A, B, C    decoder select, A = idx[2], C = idx[0]
//    en         decoder enable
//    busy       scan in progress
//    done       one-cycle pulse when a scan ends
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no scan, en = 0, ABC = 000
// DRIVE | en = 1 on idx_q, counting the dwell down to zero
// BLANK | en = 0 with ABC held, counting the blanking down to zero
module decoder_scan_ctrl #(
   parameter int DWELL_W   = 8,
   parameter int BLANK_CYC = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               mode_cont,
   input  logic [7:0]         mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic               A,
   output logic               B,
   output logic               C,
   output logic               en,
   output logic               busy,
   output logic               done
);

   localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [BW-1:0] BLANK_LD = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      BLANK = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [BW-1:0]      bcnt_q, bcnt_d;
   logic               stop_q, stop_d;
   logic               en_q, en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [7:0]         hi_mask;
   logic [3:0]         low_all;
   logic [3:0]         low_hi;
   logic [DWELL_W-1:0] dwell_ld;
   logic               sel;

   // {found, index} of the lowest set bit.
   function automatic logic [3:0] lowest(input logic [7:0] m);
      lowest = 4'b0000;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) lowest = {1'b1, 3'(i)};
      end
   endfunction

   // Bits strictly above idx_q; for idx 7 the shift overflows to zero,
   // which correctly leaves nothing above.
   assign hi_mask  = mask & ~((8'd2 << idx_q) - 8'd1);
   assign low_all  = lowest(mask);
   assign low_hi   = lowest(hi_mask);
   // The counter terminates at zero, so load one less than the slot length.
   assign dwell_ld = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;
      stop_d  = stop_q;
      done_d  = 1'b0;
      sel     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (low_all[3]) begin
                  state_d = DRIVE;
                  idx_d   = low_all[2:0];
                  cnt_d   = dwell_ld;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         DRIVE: begin
            stop_d = stop_q | stop;
            if (cnt_q == '0) begin
               if (BLANK_CYC > 0) begin
                  state_d = BLANK;
                  bcnt_d  = BLANK_LD;
               end else begin
                  sel = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         BLANK: begin
            stop_d = stop_q | stop;
            if (bcnt_q == '0) sel = 1'b1;
            else              bcnt_d = bcnt_q - BW'(1);
         end
         default: state_d = IDLE;
      endcase

      // A stop arriving on the final cycle of a slot still ends the scan.
      if (sel) begin
         if (stop_q || stop) begin
            state_d = IDLE;
         end else if (low_hi[3]) begin
            state_d = DRIVE;
            idx_d   = low_hi[2:0];
            cnt_d   = dwell_ld;
         end else if (mode_cont && low_all[3]) begin
            state_d = DRIVE;
            idx_d   = low_all[2:0];
            cnt_d   = dwell_ld;
         end else begin
            state_d = IDLE;
         end
         if (state_d == IDLE) begin
            done_d = 1'b1;
            idx_d  = 3'b000;
            stop_d = 1'b0;
         end
      end

      en_d   = (state_d == DRIVE);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 3'b000;
         cnt_q   <= '0;
         bcnt_q  <= '0;
         stop_q  <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
         stop_q  <= stop_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign A    = idx_q[2];
   assign B    = idx_q[1];
   assign C    = idx_q[0];
   assign en   = en_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: expected per-cycle output vectors
// {en, A, B, C, busy, done} are queued from a slot-level description of
// each scan and popped one per cycle as the DUT runs.
module tb_decoder_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       start0 = 1'b0;
   logic       stop = 1'b0;
   logic       mode_cont = 1'b0;
   logic [7:0] mask = 8'h00;
   logic [7:0] dwell = 8'd0;

   logic A, B, C, en, busy, done;
   logic A0, B0, C0, en0, busy0, done0;
   logic [7:0] y_dec;

   int n_cmp = 0;
   int n_err = 0;
   logic [5:0] exp_q[$];

   always #5 clk = ~clk;

   decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYC(1)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_cont(mode_cont),
      .mask(mask), .dwell(dwell), .A(A), .B(B), .C(C), .en(en), .busy(busy), .done(done)
   );

   decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYC(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .stop(stop), .mode_cont(mode_cont),
      .mask(mask), .dwell(dwell), .A(A0), .B(B0), .C(C0), .en(en0), .busy(busy0), .done(done0)
   );

   // Behavioural 3-to-8 decoder fed by the controller.
   assign y_dec = en ? (8'd1 << {A, B, C}) : 8'h00;

   function automatic logic [5:0] ent(input logic e, input logic [2:0] idx,
                                      input logic b, input logic d);
      ent = {e, idx, b, d};
   endfunction

   task automatic push_slot(input int idx, input int d, input int nb);
      int deff;
      deff = (d == 0) ? 1 : d;
      for (int i = 0; i < deff; i++) exp_q.push_back(ent(1'b1, 3'(idx), 1'b1, 1'b0));
      for (int i = 0; i < nb; i++)   exp_q.push_back(ent(1'b0, 3'(idx), 1'b1, 1'b0));
   endtask

   task automatic push_end();
      exp_q.push_back(ent(1'b0, 3'd0, 1'b0, 1'b1));
      exp_q.push_back(ent(1'b0, 3'd0, 1'b0, 1'b0));
   endtask

   // act: 1 = pulse stop, 2 = load act_mask, 3 = pulse start, 4 = pulse rst,
   // applied right after comparing entry act_at.
   task automatic run_check(input string name, input bit sel0, input int act_at,
                            input int act, input logic [7:0] act_mask);
      int n;
      logic [5:0] e, obs;
      logic [7:0] y_exp;
      n = 0;
      if (sel0) start0 = 1'b1;
      else      start  = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            start  = 1'b0;
            start0 = 1'b0;
         end
         if (n == act_at + 1) begin
            stop = 1'b0;
            rst  = 1'b0;
            if (act == 3) start = 1'b0;
         end
         e   = exp_q.pop_front();
         obs = sel0 ? {en0, A0, B0, C0, busy0, done0} : {en, A, B, C, busy, done};
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL %s cycle %0d: {en,ABC,busy,done} got %b expected %b", name, n, obs, e);
         end
         if (!sel0) begin
            y_exp = e[5] ? (8'd1 << e[4:2]) : 8'h00;
            n_cmp++;
            if (y_dec !== y_exp) begin
               n_err++;
               $display("FAIL %s_Y cycle %0d: got %b expected %b", name, n, y_dec, y_exp);
            end
         end
         if (n == act_at) begin
            case (act)
               1: stop  = 1'b1;
               2: mask  = act_mask;
               3: start = 1'b1;
               4: rst   = 1'b1;
               default: ;
            endcase
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({en, A, B, C, busy, done} !== 6'b0) begin
         n_err++;
         $display("FAIL reset: got %b expected %b", {en, A, B, C, busy, done}, 6'b0);
      end
      n_cmp++;
      if ({en0, A0, B0, C0, busy0, done0} !== 6'b0) begin
         n_err++;
         $display("FAIL reset0: got %b expected %b", {en0, A0, B0, C0, busy0, done0}, 6'b0);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_pass();
      mask = 8'b0000_0101; dwell = 8'd2; mode_cont = 1'b0;
      push_slot(0, 2, 1);
      push_slot(2, 2, 1);
      push_end();
      run_check("single_pass", 1'b0, 0, 0, 8'h00);
   endtask

   task automatic test_cont_stop();
      mask = 8'b1000_0010; dwell = 8'd1; mode_cont = 1'b1;
      push_slot(1, 1, 1);
      push_slot(7, 1, 1);
      push_slot(1, 1, 1);
      push_slot(7, 1, 1);
      push_end();
      run_check("cont_stop", 1'b0, 7, 1, 8'h00);
      mode_cont = 1'b0;
   endtask

   task automatic test_dwell_zero();
      mask = 8'b0000_0011; dwell = 8'd0;
      push_slot(0, 0, 1);
      push_slot(1, 0, 1);
      push_end();
      run_check("dwell_zero", 1'b0, 0, 0, 8'h00);
      mask = 8'h00;
      push_end();
      exp_q.push_back(ent(1'b0, 3'd0, 1'b0, 1'b0));
      run_check("empty_mask", 1'b0, 0, 0, 8'h00);
   endtask

   task automatic test_mask_change();
      mask = 8'hFF; dwell = 8'd3;
      push_slot(0, 3, 1);
      push_slot(1, 3, 1);
      push_slot(2, 3, 1);
      for (int i = 4; i < 8; i++) push_slot(i, 3, 1);
      push_end();
      run_check("mask_change", 1'b0, 9, 2, 8'hF3);
   endtask

   task automatic test_start_ignored();
      mask = 8'b0100_1000; dwell = 8'd2;
      push_slot(3, 2, 1);
      push_slot(6, 2, 1);
      push_end();
      run_check("start_busy", 1'b0, 1, 3, 8'h00);
   endtask

   task automatic test_back_to_back();
      mask = 8'b0001_0000; dwell = 8'd1;
      push_slot(4, 1, 1);
      exp_q.push_back(ent(1'b0, 3'd0, 1'b0, 1'b1));
      push_slot(4, 1, 1);
      push_end();
      run_check("back_to_back", 1'b0, 3, 3, 8'h00);
   endtask

   task automatic test_reset_mid();
      mask = 8'b0110_0001; dwell = 8'd4;
      push_slot(0, 4, 1);
      exp_q.push_back(ent(1'b1, 3'd5, 1'b1, 1'b0));
      exp_q.push_back(ent(1'b1, 3'd5, 1'b1, 1'b0));
      exp_q.push_back(ent(1'b0, 3'd0, 1'b0, 1'b0));
      run_check("reset_mid", 1'b0, 7, 4, 8'h00);
      push_slot(0, 4, 1);
      push_slot(5, 4, 1);
      push_slot(6, 4, 1);
      push_end();
      run_check("restart", 1'b0, 0, 0, 8'h00);
   endtask

   task automatic test_no_blank();
      mask = 8'b0000_1011; dwell = 8'd2;
      push_slot(0, 2, 0);
      push_slot(1, 2, 0);
      push_slot(3, 2, 0);
      push_end();
      run_check("no_blank", 1'b1, 0, 0, 8'h00);
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_cont_stop();
      test_dwell_zero();
      test_mask_change();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      test_no_blank();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
